// File: rtl/jt6295_pkg.sv
// Shared types and constants for the JT6295 command decoder / phrase fetcher.
package jt6295_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FETCH2 = 3'd3,
    FETCH3 = 3'd4,
    FETCH4 = 3'd5,
    FETCH5 = 3'd6,
    ISSUE  = 3'd7
  } state_t;

  localparam int TBL_BYTES = 6;
  localparam int START_BIT = 7;
  localparam int BANK_BIT  = 2;

  // Fields sized for the widest legal configuration; narrower builds truncate.
  typedef struct packed {
    logic [6:0] phrase;
    logic [7:0] mask;
    logic [3:0] att;
  } req_t;
endpackage

// File: rtl/jt6295_ctrl_q_if.sv
// CPU write port and phrase-table ROM port of the JT6295 controller.
interface jt6295_ctrl_q_if #(parameter int PHW = 7);
  // A CPU write is one clk with wrn low after a clk with wrn high; din is valid then.
  // The ROM answers rom_addr with rom_data whenever rom_ok is high; the controller
  // holds rom_addr and waits at least one clk after changing it before sampling.
  logic           wrn;
  logic [7:0]     din;
  logic [PHW+2:0] rom_addr;
  logic [7:0]     rom_data;
  logic           rom_ok;

  modport master (output wrn, din, rom_data, rom_ok, input rom_addr);
  modport slave  (input wrn, din, rom_data, rom_ok, output rom_addr);
endinterface

// File: rtl/jt6295_reqfifo.sv
// Start-request FIFO: head is visible combinationally, push/pop in one cycle allowed.
module jt6295_reqfifo #(
  parameter int W  = 19,
  parameter int QD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [W-1:0]         i_din,
  output logic [W-1:0]         o_dout,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [$clog2(QD):0]  o_level
);
  localparam int PW = $clog2(QD);
  localparam int LW = PW + 1;

  logic [W-1:0]  r_mem [QD];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(QD));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rp];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + PW'(1);
      if (w_do_pop)  r_rp <= r_rp + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/jt6295_ctrl_q.sv
// JT6295 command decoder: queues CPU start commands, fetches phrase addresses
// from the ROM table and raises per-channel start/stop requests.
module jt6295_ctrl_q
  import jt6295_pkg::*;
#(
  parameter int CH          = 4,
  parameter int AW          = 18,
  parameter int PHW         = 7,
  parameter int QD          = 4,
  parameter int BUSY_REJECT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen4,
  jt6295_ctrl_q_if.slave      bus,
  output logic [AW-1:0]       start_addr,
  output logic [AW-1:0]       stop_addr,
  output logic [3:0]          att,
  output logic [CH-1:0]       start,
  output logic [CH-1:0]       stop,
  input  logic [CH-1:0]       busy,
  input  logic [CH-1:0]       ack,
  output logic                ovf,
  output logic [$clog2(QD):0] qlevel,
  output state_t              dbg_state
);
  function automatic logic [CH-1:0] place(input logic [3:0] nib, input logic bank);
    logic [7:0] v;
    v = {4'b0, nib} << (bank ? 4 : 0);
    return v[CH-1:0];
  endfunction

  state_t         r_state, w_state_nx;
  logic           r_last_wrn, r_cmd, r_bank, r_settle, r_ovf;
  logic [PHW-1:0] r_phrase;
  logic [PHW+2:0] r_rom_addr, w_rom_addr_nx;
  logic [47:0]    r_tbl;
  req_t           r_cur, w_push_data, w_head;
  logic [CH-1:0]  r_start, r_stop, w_mask, w_eff;
  logic [AW-1:0]  r_start_addr, r_stop_addr;
  logic [3:0]     r_att;
  logic           w_we, w_stop_wr, w_bank_wr, w_push, w_pop, w_full, w_empty;
  logic           w_cap, w_issue, w_settle_nx;
  logic [2:0]     w_idx;
  logic           w_unused;

  assign w_we      = !bus.wrn && r_last_wrn;
  assign w_bank_wr = w_we && !r_cmd && !bus.din[START_BIT] && bus.din[BANK_BIT] && (CH == 8);
  assign w_stop_wr = w_we && !r_cmd && !bus.din[START_BIT] && !w_bank_wr;
  assign w_push    = w_we && r_cmd && (bus.din[7:4] != 4'd0) && (r_phrase != '0);
  assign w_mask    = r_cur.mask[CH-1:0];
  assign w_eff     = (BUSY_REJECT != 0) ? (w_mask & ~busy) : w_mask;
  assign w_idx     = 3'(r_state) - 3'(FETCH0);
  assign w_unused  = ^{r_tbl, r_cur};

  always_comb begin
    w_push_data        = '0;
    w_push_data.phrase = 7'(r_phrase);
    w_push_data.mask   = 8'(place(bus.din[7:4], r_bank));
    w_push_data.att    = bus.din[3:0];
  end

  jt6295_reqfifo #(.W($bits(req_t)), .QD(QD)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (qlevel)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Each table byte costs two clk: one to let the new rom_addr settle, one to sample.
  always_comb begin
    w_state_nx    = r_state;
    w_pop         = 1'b0;
    w_rom_addr_nx = r_rom_addr;
    w_settle_nx   = 1'b1;
    w_cap         = 1'b0;
    w_issue       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop         = 1'b1;
        w_state_nx    = FETCH0;
        w_rom_addr_nx = {PHW'(w_head.phrase), 3'd0};
        w_settle_nx   = 1'b0;
      end
      ISSUE: begin
        w_issue    = 1'b1;
        w_state_nx = IDLE;
      end
      default: if (r_settle && bus.rom_ok) begin
        w_cap       = 1'b1;
        w_settle_nx = 1'b0;
        if (r_state == FETCH5) begin
          w_state_nx = ISSUE;
        end else begin
          w_state_nx    = state_t'(3'(r_state) + 3'd1);
          w_rom_addr_nx = {PHW'(r_cur.phrase), w_idx + 3'd1};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_wrn   <= 1'b1;
      r_cmd        <= 1'b0;
      r_bank       <= 1'b0;
      r_phrase     <= '0;
      r_ovf        <= 1'b0;
      r_stop       <= '0;
      r_start      <= '0;
      r_cur        <= '0;
      r_tbl        <= '0;
      r_settle     <= 1'b0;
      r_rom_addr   <= '0;
      r_start_addr <= '0;
      r_stop_addr  <= '0;
      r_att        <= '0;
    end else begin
      r_last_wrn <= bus.wrn;
      r_settle   <= w_settle_nx;
      r_rom_addr <= w_rom_addr_nx;
      if (w_we) begin
        if (r_cmd) r_cmd <= 1'b0;
        else if (bus.din[START_BIT]) begin
          r_cmd    <= 1'b1;
          r_phrase <= PHW'(bus.din[6:0]);
        end
      end
      if (w_bank_wr) r_bank <= bus.din[0];
      if (w_push && w_full) r_ovf <= 1'b1;
      // A stop write in the same cycle as cen4 skips the busy-based clear.
      if (w_stop_wr) r_stop <= r_stop | place(bus.din[6:3], r_bank);
      else if (cen4) r_stop <= r_stop & busy;
      if (w_pop) r_cur <= w_head;
      if (w_cap) r_tbl <= {r_tbl[39:0], bus.rom_data};
      if (r_state == IDLE) r_start <= r_start & ~ack;
      else if (w_issue && (w_eff != '0)) begin
        r_start      <= r_start | w_eff;
        r_start_addr <= r_tbl[24 +: AW];
        r_stop_addr  <= r_tbl[0 +: AW];
        r_att        <= r_cur.att;
      end
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign start        = r_start;
  assign stop         = r_stop;
  assign start_addr   = r_start_addr;
  assign stop_addr    = r_stop_addr;
  assign att          = r_att;
  assign ovf          = r_ovf;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_jt6295_ctrl_q.sv
// Directed bench for jt6295_ctrl_q: u0 is CH=4/AW=18/busy-reject, u1 is CH=8/AW=16/no reject.
module tb_jt6295_ctrl_q;
  import jt6295_pkg::*;

  logic       clk = 1'b0;
  logic       rst, cen4, wrn, rom_ok;
  logic [7:0] din, busy8, ack8;

  logic [17:0] sa0, spa0;
  logic [15:0] sa1, spa1;
  logic [3:0]  att0, att1, start0, stop0;
  logic [7:0]  start1, stop1;
  logic        ovf0, ovf1;
  logic [2:0]  ql0, ql1;
  state_t      st0, st1;

  int n_chk = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  jt6295_ctrl_q_if #(.PHW(7)) bus0 ();
  jt6295_ctrl_q_if #(.PHW(7)) bus1 ();

  assign bus0.wrn = wrn;   assign bus1.wrn = wrn;
  assign bus0.din = din;   assign bus1.din = din;
  assign bus0.rom_ok = rom_ok;  assign bus1.rom_ok = rom_ok;

  // Phrase table; phrases 1, 3, 5 have hand-picked contents.
  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    logic [47:0] t;
    int n;
    n = int'(a[2:0]);
    case (a[9:3])
      7'd1:    t = 48'h0FFFFF_3C0001;
      7'd3:    t = 48'h00ABCD_012345;
      7'd5:    t = 48'h001234_005678;
      default: return {a[6:3], 1'b0, a[2:0]};
    endcase
    if (n > 5) return 8'h00;
    return t[8*(5-n) +: 8];
  endfunction

  // ROM with one clk of latency
  always @(posedge clk) begin
    bus0.rom_data <= rom_fn(bus0.rom_addr);
    bus1.rom_data <= rom_fn(bus1.rom_addr);
  end

  jt6295_ctrl_q #(.CH(4), .AW(18), .PHW(7), .QD(4), .BUSY_REJECT(1)) u0 (
    .clk(clk), .rst(rst), .cen4(cen4), .bus(bus0.slave),
    .start_addr(sa0), .stop_addr(spa0), .att(att0),
    .start(start0), .stop(stop0), .busy(busy8[3:0]), .ack(ack8[3:0]),
    .ovf(ovf0), .qlevel(ql0), .dbg_state(st0)
  );

  jt6295_ctrl_q #(.CH(8), .AW(16), .PHW(7), .QD(4), .BUSY_REJECT(0)) u1 (
    .clk(clk), .rst(rst), .cen4(cen4), .bus(bus1.slave),
    .start_addr(sa1), .stop_addr(spa1), .att(att1),
    .start(start1), .stop(stop1), .busy(busy8), .ack(ack8),
    .ovf(ovf1), .qlevel(ql1), .dbg_state(st1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wrn = 1'b1; din = 8'h00; cen4 = 1'b0;
    rom_ok = 1'b1; busy8 = 8'h00; ack8 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b, input logic c = 1'b0);
    @(negedge clk);
    din = b; wrn = 1'b0; cen4 = c;
    @(negedge clk);
    wrn = 1'b1; cen4 = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget);
    int k;
    k = 0;
    while (st0 != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_state", 32'(st0), 32'(s));
  endtask

  // scoreboard: expected attenuation of each ISSUE on u0, in order
  logic [3:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         issue_seen = 1'b0;
  int         n_issue = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (issue_seen) begin
        n_issue++;
        if (exp_q.size() > 0) chk("issue_att", 32'(att0), 32'(exp_q.pop_front()));
      end
      issue_seen = (st0 == ISSUE);
    end else begin
      issue_seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    do_reset();
    chk("rst_start", 32'(start0), 0);
    chk("rst_stop", 32'(stop0), 0);
    chk("rst_saddr", 32'(sa0), 0);
    chk("rst_eaddr", 32'(spa0), 0);
    chk("rst_att", 32'(att0), 0);
    chk("rst_romaddr", 32'(bus0.rom_addr), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_qlevel", 32'(ql0), 0);
    chk("rst_state", 32'(st0), 32'(IDLE));

    // basic start: 15th edge from the second byte raises start
    wr(8'h85); wr(8'h2A);
    repeat (13) @(negedge clk);
    chk("lat_early", 32'(start0), 0);
    @(negedge clk);
    chk("t1_start", 32'(start0), 32'h2);
    chk("t1_saddr", 32'(sa0), 32'h01234);
    chk("t1_eaddr", 32'(spa0), 32'h05678);
    chk("t1_att", 32'(att0), 32'hA);
    chk("t1_start_u1", 32'(start1), 32'h02);
    repeat (3) @(negedge clk);
    chk("t1_hold", 32'(start0), 32'h2);
    ack8 = 8'h02;
    @(negedge clk);
    chk("t1_ack", 32'(start0), 0);
    chk("t1_ack_u1", 32'(start1), 0);
    ack8 = 8'h00;

    // discarded commands: phrase 0, mask 0
    wr(8'h80); wr(8'h35);
    chk("disc_phrase0", 32'(ql0), 0);
    wr(8'h85); wr(8'h05);
    chk("disc_mask0", 32'(ql0), 0);
    chk("disc_state", 32'(st0), 32'(IDLE));

    // overflow: first request is popped and stalls in FETCH0, next four fill
    // the FIFO, the sixth is dropped
    do_reset();
    rom_ok = 1'b0;
    wr(8'h82); wr(8'h11);
    wr(8'h83); wr(8'h22);
    wr(8'h84); wr(8'h43);
    wr(8'h86); wr(8'h84);
    wr(8'h87); wr(8'h15);
    wr(8'h85); wr(8'h26);
    chk("ovf_qlevel", 32'(ql0), 4);
    chk("ovf_flag", 32'(ovf0), 1);
    chk("ovf_stall", 32'(st0), 32'(FETCH0));
    chk("ovf_romaddr", 32'(bus0.rom_addr), 32'h010);
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    mon_en = 1'b1;
    rom_ok = 1'b1;
    k = 0;
    while (n_issue < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    chk("ovf_issues", 32'(n_issue), 5);
    chk("ovf_q_empty", 32'(exp_q.size()), 0);
    chk("ovf_qlevel_end", 32'(ql0), 0);
    chk("ovf_start", 32'(start0), 32'hF);

    // reset in the middle of a fetch
    wr(8'h85); wr(8'h2A);
    wait_state(FETCH3, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_start", 32'(start0), 0);
    chk("mid_qlevel", 32'(ql0), 0);
    chk("mid_state", 32'(st0), 32'(IDLE));
    chk("mid_ovf", 32'(ovf0), 0);
    wr(8'h85); wr(8'h2A);
    repeat (14) @(negedge clk);
    chk("mid_again_start", 32'(start0), 32'h2);
    chk("mid_again_saddr", 32'(sa0), 32'h01234);

    // busy rejection vs. forced start
    do_reset();
    busy8 = 8'h01;
    wr(8'h83); wr(8'h30);
    repeat (14) @(negedge clk);
    chk("br_start_u0", 32'(start0), 32'h2);
    chk("br_saddr_u0", 32'(sa0), 32'h0ABCD);
    chk("br_eaddr_u0", 32'(spa0), 32'h12345);
    chk("br_start_u1", 32'(start1), 32'h03);
    chk("br_saddr_u1", 32'(sa1), 32'hABCD);
    chk("br_eaddr_u1", 32'(spa1), 32'h2345);
    ack8 = 8'h03;
    @(negedge clk);
    ack8 = 8'h00;
    busy8 = 8'h03;
    wr(8'h81); wr(8'h3C);
    repeat (14) @(negedge clk);
    chk("br_all_busy_start", 32'(start0), 0);
    chk("br_all_busy_att", 32'(att0), 0);
    chk("br_all_busy_saddr", 32'(sa0), 32'h0ABCD);
    chk("br_force_start", 32'(start1), 32'h03);
    chk("br_force_saddr", 32'(sa1), 32'hFFFF);
    chk("br_force_eaddr", 32'(spa1), 32'h0001);
    chk("br_force_att", 32'(att1), 32'hC);
    busy8 = 8'h00;
    wr(8'h81); wr(8'h3C);
    repeat (14) @(negedge clk);
    chk("trunc_start", 32'(start0), 32'h3);
    chk("trunc_saddr", 32'(sa0), 32'h3FFFF);
    chk("trunc_eaddr", 32'(spa0), 32'h00001);

    // stop requests held until the channel goes idle
    do_reset();
    busy8 = 8'hFF;
    wr(8'h48);
    chk("stop_set_u0", 32'(stop0), 32'h9);
    chk("stop_set_u1", 32'(stop1), 32'h09);
    busy8 = 8'hFE;
    @(negedge clk); cen4 = 1'b1;
    @(negedge clk); cen4 = 1'b0;
    chk("stop_clr_u0", 32'(stop0), 32'h8);
    chk("stop_clr_u1", 32'(stop1), 32'h08);
    busy8 = 8'h00;
    wr(8'h10, 1'b1);
    chk("stop_wr_wins", 32'(stop0), 32'hA);
    @(negedge clk); cen4 = 1'b1;
    @(negedge clk); cen4 = 1'b0;
    chk("stop_idle", 32'(stop0), 0);

    // channel banking on the 8-channel build
    do_reset();
    wr(8'h05);
    wr(8'h81); wr(8'h10);
    repeat (14) @(negedge clk);
    chk("bank_start_u1", 32'(start1), 32'h10);
    chk("bank_start_u0", 32'(start0), 32'h1);
    wr(8'h08);
    chk("bank_stop_u1", 32'(stop1), 32'h10);
    chk("bank_stop_u0", 32'(stop0), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
